// File: rtl/music_pkg.sv
// Shared types and constants for the note sequencer that feeds the music beeper engine.
package music_pkg;

    localparam logic [7:0] MUSIC_RESYNC_BYTE = 8'hFF;
    localparam logic [7:0] MUSIC_TIME_ZERO   = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } music_state_e;

    // "time" is a reserved word, so the duration field is time_code.
    typedef struct packed {
        logic [7:0] note;
        logic [7:0] time_code;
    } music_cmd_t;

    // A time byte that completes a storable command: not resync and not zero.
    function automatic logic is_cmd_time(input logic [7:0] b);
        return (b != MUSIC_RESYNC_BYTE) && (b != MUSIC_TIME_ZERO);
    endfunction

endpackage

// File: rtl/music_note_seq_if.sv
// Command handshake between the note sequencer (master) and the beeper engine (slave).
interface music_note_seq_if;

    logic       en;
    logic [7:0] music_note;
    logic [7:0] music_time;
    logic       music_busy;

    modport master (
        output en,
        output music_note,
        output music_time,
        input  music_busy
    );

    modport slave (
        input  en,
        input  music_note,
        input  music_time,
        output music_busy
    );

endinterface

// File: rtl/music_cmd_fifo.sv
// First-word-fall-through command FIFO; level and full are registered.
module music_cmd_fifo
    import music_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  music_cmd_t               push_data,
    input  logic                     pop,
    output music_cmd_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    music_cmd_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and level already mark every slot invalid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10: begin
                    level <= level + LW'(1);
                    full  <= (level == LW'(DEPTH - 1));
                end
                2'b01: begin
                    level <= level - LW'(1);
                    full  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/music_note_seq.sv
// Pairs UART bytes into (note, time) commands, queues them and issues them to the beeper engine.
// Optional saturating drop counter output enabled by `define MUSIC_NOTE_SEQ_DROP_CNT_EN.
module music_note_seq
    import music_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ACK_WAIT   = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    music_note_seq_if.master              eng,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef MUSIC_NOTE_SEQ_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_cnt
`endif
);

    localparam int CW = $clog2(ACK_WAIT + 1);

    logic          half;
    logic [7:0]    note_hold;
    logic          pair_push;
    music_cmd_t    push_data;
    music_cmd_t    head;
    logic          fifo_empty;
    logic          pop;
    music_state_e  state_q;
    music_state_e  state_d;
    logic [CW-1:0] ack_cnt;

    assign pair_push = rx_valid && half && is_cmd_time(rx_data);
    assign push_data = '{note: note_hold, time_code: rx_data};

    // Resync wins over either half; a resync or zero-time pair leaves nothing behind.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            half      <= 1'b0;
            note_hold <= '0;
        end else if (rx_valid) begin
            if (rx_data == MUSIC_RESYNC_BYTE) begin
                half <= 1'b0;
            end else if (!half) begin
                note_hold <= rx_data;
                half      <= 1'b1;
            end else begin
                half <= 1'b0;
            end
        end
    end

    music_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (pair_push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        eng.en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                eng.en  = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (eng.music_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt <= CW'(1)) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!eng.music_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The ack window covers exactly ACK_WAIT cycles of WAIT_ACK.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ack_cnt <= '0;
        end else if (state_q == ISSUE) begin
            ack_cnt <= CW'(ACK_WAIT);
        end else if (state_q == WAIT_ACK && ack_cnt != '0) begin
            ack_cnt <= ack_cnt - CW'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            eng.music_note <= '0;
            eng.music_time <= '0;
        end else if (pop) begin
            eng.music_note <= head.note;
            eng.music_time <= head.time_code;
        end
    end

`ifdef MUSIC_NOTE_SEQ_DROP_CNT_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            drop_cnt <= '0;
        end else if (pair_push && fifo_full && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_music_note_seq.sv
// Self-checking bench for music_note_seq: directed corner cases, a vector table and random bursts.
module tb_music_note_seq;
    import music_pkg::*;

    localparam int DEPTH = 8;
    localparam int ACK_W = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          fifo_full;
    logic [LW-1:0] fifo_level;
`ifdef MUSIC_NOTE_SEQ_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    music_note_seq_if eng ();

    music_note_seq #(
        .FIFO_DEPTH (DEPTH),
        .ACK_WAIT   (ACK_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .eng        (eng),
        .fifo_full  (fifo_full),
        .fifo_level (fifo_level)
`ifdef MUSIC_NOTE_SEQ_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte pairing rules plus an ordered list of commands still to be issued.
    music_cmd_t exp_q[$];
    bit         m_half  = 1'b0;
    logic [7:0] m_note  = '0;
    int         m_cnt   = 0;
    int         m_drops = 0;

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hFF) begin
            m_half = 1'b0;
        end else if (!m_half) begin
            m_note = b;
            m_half = 1'b1;
        end else begin
            m_half = 1'b0;
            if (b != 8'h00) begin
                if (m_cnt >= DEPTH) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_cnt++;
                    exp_q.push_back('{note: m_note, time_code: b});
                end
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_half  = 1'b0;
        m_cnt   = 0;
        m_drops = 0;
    endtask

    // Monitor: every en pulse is scored against the model's next command.
    int         en_count = 0;
    int         en_cyc[$];
    logic [7:0] last_note, last_time;
    bit         prev_en = 1'b0;
    bit         en_seen = 1'b0;
    music_cmd_t exp_c;

    always @(negedge sys_clk) begin
        if (!sys_rst && eng.en === 1'b1) begin
            en_count++;
            en_cyc.push_back(cyc);
            en_seen = 1'b1;
            check("en_one_cycle", 32'(prev_en), 32'd0);
            if (exp_q.size() == 0) begin
                check("en_unexpected", 32'd1, 32'd0);
            end else begin
                exp_c = exp_q.pop_front();
                check("cmd_note", 32'(eng.music_note), 32'(exp_c.note));
                check("cmd_time", 32'(eng.music_time), 32'(exp_c.time_code));
                if (m_cnt > 0) m_cnt--;
            end
            last_note = eng.music_note;
            last_time = eng.music_time;
        end
        prev_en = (eng.en === 1'b1);
    end

    // Engine model: forced busy level, or a reaction to each en (delay, play length, or silence).
    int eng_mode   = 1;
    bit busy_force = 1'b0;
    bit eng_never  = 1'b0;
    bit eng_rand   = 1'b0;
    int eng_d      = 1;
    int eng_len    = 10;
    int wait_cnt   = 0;
    int play_cnt   = 0;
    bit e_never;
    int e_d, e_len;

    always begin
        @(posedge sys_clk);
        #1;
        if (sys_rst) begin
            eng.music_busy = 1'b0;
            wait_cnt = 0;
            play_cnt = 0;
            en_seen  = 1'b0;
        end else if (eng_mode == 1) begin
            eng.music_busy = busy_force;
            wait_cnt = 0;
            play_cnt = 0;
            en_seen  = 1'b0;
        end else begin
            if (en_seen) begin
                en_seen = 1'b0;
                e_never = eng_never;
                e_d     = eng_d;
                e_len   = eng_len;
                if (eng_rand) begin
                    e_never = ($urandom_range(0, 3) == 0);
                    e_d     = $urandom_range(1, 2);
                    e_len   = $urandom_range(1, 5);
                end
                if (!e_never) wait_cnt = e_d;
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    eng.music_busy = 1'b1;
                    play_cnt = e_len;
                end
            end else if (play_cnt > 0) begin
                play_cnt--;
                if (play_cnt == 0) eng.music_busy = 1'b0;
            end else begin
                eng.music_busy = 1'b0;
            end
        end
    end

    int last_cyc;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        last_cyc = cyc;
        model_byte(b);
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || eng.music_busy === 1'b1 || wait_cnt != 0 || play_cnt != 0)
               && n < 400) begin
            idle(1);
            n++;
        end
        check({name, "_drain_in_time"}, 32'(n < 400), 32'd1);
        idle(ACK_W + 8);
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         n_cmd;
        logic [7:0] note;
        logic [7:0] time_code;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n0, k0, nb;
        logic [7:0] b;

        vecs[0] = '{8'h7F, 8'h01, 1, 8'h7F, 8'h01};
        vecs[1] = '{8'h00, 8'h80, 1, 8'h00, 8'h80};
        vecs[2] = '{8'hFE, 8'hFE, 1, 8'hFE, 8'hFE};
        vecs[3] = '{8'h42, 8'h00, 0, 8'h00, 8'h00};
        vecs[4] = '{8'hFF, 8'hFF, 0, 8'h00, 8'h00};
        vecs[5] = '{8'h01, 8'hFF, 0, 8'h00, 8'h00};
        vecs[6] = '{8'hA5, 8'h5A, 1, 8'hA5, 8'h5A};

        sys_rst  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        idle(3);
        check("rst_en",    32'(eng.en),         32'd0);
        check("rst_note",  32'(eng.music_note), 32'd0);
        check("rst_time",  32'(eng.music_time), 32'd0);
        check("rst_full",  32'(fifo_full),      32'd0);
        check("rst_level", 32'(fifo_level),     32'd0);
`ifdef MUSIC_NOTE_SEQ_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        sys_rst = 1'b0;
        eng_mode = 0;
        idle(2);

        // Single command with latency: en lands two cycles after the time byte.
        n0 = en_count;
        send_byte(8'h15);
        send_byte(8'h20);
        check("single_level_n1", 32'(fifo_level), 32'd1);
        check("single_en_n1", 32'(eng.en), 32'd0);
        idle(1);
        check("single_en_n2", 32'(eng.en), 32'd1);
        check("single_note_n2", 32'(eng.music_note), 32'h15);
        check("single_time_n2", 32'(eng.music_time), 32'h20);
        wait_drain("single");
        check("single_count", 32'(en_count - n0), 32'd1);
        check("single_en_cycle", 32'(en_cyc[$]), 32'(last_cyc + 2));
        check("single_note_hold", 32'(eng.music_note), 32'h15);

        // Resync discards the held note.
        n0 = en_count;
        send_byte(8'h15);
        send_byte(8'hFF);
        send_byte(8'h21);
        send_byte(8'h08);
        wait_drain("resync");
        check("resync_count", 32'(en_count - n0), 32'd1);
        check("resync_note", 32'(last_note), 32'h21);
        check("resync_time", 32'(last_time), 32'h08);

        // Zero-time pair is discarded and pairing restarts cleanly.
        n0 = en_count;
        send_byte(8'h30);
        send_byte(8'h00);
        idle(4);
        check("tz_level", 32'(fifo_level), 32'd0);
        check("tz_no_en", 32'(en_count - n0), 32'd0);
        send_byte(8'h31);
        send_byte(8'h05);
        wait_drain("tz");
        check("tz_count", 32'(en_count - n0), 32'd1);
        check("tz_note", 32'(last_note), 32'h31);
        check("tz_time", 32'(last_time), 32'h05);

        foreach (vecs[i]) begin
            n0 = en_count;
            send_byte(vecs[i].b0);
            send_byte(vecs[i].b1);
            wait_drain("vec");
            check("vec_count", 32'(en_count - n0), 32'(vecs[i].n_cmd));
            if (vecs[i].n_cmd != 0) begin
                check("vec_note", 32'(last_note), 32'(vecs[i].note));
                check("vec_time", 32'(last_time), 32'(vecs[i].time_code));
            end
        end

        // Ack timeout: silent engine, pulses spaced ACK_WAIT+2 apart.
        eng_never = 1'b1;
        n0 = en_count;
        k0 = en_cyc.size();
        send_byte(8'h11); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h02);
        send_byte(8'h13); send_byte(8'h03);
        wait_drain("timeout");
        check("timeout_count", 32'(en_count - n0), 32'd3);
        for (int i = 1; i < 3; i++) begin
            check("timeout_gap", 32'(en_cyc[k0 + i] - en_cyc[k0 + i - 1]), 32'(ACK_W + 2));
        end
        eng_never = 1'b0;

        // Overflow: engine held busy on a first command, then ten pairs arrive.
        eng_mode   = 1;
        busy_force = 1'b1;
        send_byte(8'h40);
        send_byte(8'h01);
        idle(4);
        n0 = en_count;
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h50 + 8'(i));
            send_byte(8'h60 + 8'(i));
        end
        idle(1);
        check("ovf_level", 32'(fifo_level), 32'(DEPTH));
        check("ovf_full", 32'(fifo_full), 32'd1);
`ifdef MUSIC_NOTE_SEQ_DROP_CNT_EN
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
        eng_mode = 0;
        eng_d    = 1;
        eng_len  = 2;
        wait_drain("ovf");
        check("ovf_count", 32'(en_count - n0), 32'(DEPTH));
        check("ovf_last_note", 32'(last_note), 32'h57);
        check("ovf_full_clear", 32'(fifo_full), 32'd0);

        // Random bursts; at most DEPTH pairs per burst so no drops occur.
        eng_rand = 1'b1;
        for (int r = 0; r < 30; r++) begin
            nb = $urandom_range(1, 16);
            for (int j = 0; j < nb; j++) begin
                case ($urandom_range(0, 7))
                    0:       b = 8'hFF;
                    1:       b = 8'h00;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                if ($urandom_range(0, 3) == 0) idle(1);
                send_byte(b);
            end
            wait_drain("rand");
            check("rand_level", 32'(fifo_level), 32'd0);
        end
        eng_rand = 1'b0;
`ifdef MUSIC_NOTE_SEQ_DROP_CNT_EN
        check("rand_drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif

        // Reset while in WAIT_DONE with three pairs queued.
        eng_mode   = 1;
        busy_force = 1'b1;
        if (m_half) send_byte(8'hFF);
        send_byte(8'h70); send_byte(8'h01);
        idle(4);
        send_byte(8'h71); send_byte(8'h02);
        send_byte(8'h72); send_byte(8'h03);
        send_byte(8'h73); send_byte(8'h04);
        idle(2);
        check("mid_level", 32'(fifo_level), 32'd3);
        @(negedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        check("arst_en",    32'(eng.en),         32'd0);
        check("arst_note",  32'(eng.music_note), 32'd0);
        check("arst_time",  32'(eng.music_time), 32'd0);
        check("arst_full",  32'(fifo_full),      32'd0);
        check("arst_level", 32'(fifo_level),     32'd0);
`ifdef MUSIC_NOTE_SEQ_DROP_CNT_EN
        check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        model_reset();
        idle(3);
        eng_mode = 0;
        sys_rst  = 1'b0;
        n0 = en_count;
        idle(20);
        check("post_rst_no_en", 32'(en_count - n0), 32'd0);
        check("post_rst_level", 32'(fifo_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/music_note_seq.md
# music_note_seq

Command-side counterpart of the `music` beeper engine. It accepts a byte stream from the UART receiver and pairs bytes into (note, time) commands. Commands are buffered in a small FIFO and handed to the engine one at a time over the `en`/`music_note`/`music_time`/`music_busy` handshake. It sits between `uart_rx` and `music` in the uart_beep top level.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: command FIFO depth in (note, time) pairs. Must be a power of 2, minimum 2.
- `ACK_WAIT`, default 4: number of cycles after `en` within which `music_busy` must rise.

Ports:
- `sys_clk` in 1: the single system clock.
- `sys_rst` in 1: reset, asynchronous and active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `music_busy` in 1: engine is playing.
- `en` out 1: one-cycle command strobe to the engine.
- `music_note` out 8: note code, held stable while a command is outstanding.
- `music_time` out 8: duration code, held stable while a command is outstanding.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` pairs.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of stored pairs.

## Operation
Byte pairing, state `half` (0 = expecting note, 1 = expecting time):
- `0xFF` byte is resync: sets `half`=0 and discards any held note. The byte is never stored.
- With `half`=0, the byte is latched as the pending note and `half` becomes 1.
- With `half`=1, the byte is the time. The pair is pushed and `half` becomes 0.
- A pair with time `0x00` is discarded: no push, not counted as a drop.
- A push while `fifo_full`=1 drops the pair. Full blocks the push even if a pop happens in the same cycle.

FIFO:
- Synchronous, registered, first-word-fall-through.
- Push and pop in the same cycle while not full and not empty leaves `fifo_level` unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.

Issue FSM:
- IDLE: if FIFO is not empty, pop the head into the `music_note`/`music_time` registers and go to ISSUE.
- ISSUE: `en`=1 for this cycle only. Load the ack counter with `ACK_WAIT` and go to WAIT_ACK.
- WAIT_ACK: `music_busy`=1 goes to WAIT_DONE. If the counter reaches 0 first, the engine is treated as having rejected or finished the command, and the FSM goes to IDLE.
- WAIT_DONE: `music_busy`=0 goes to IDLE.
- Commands never overlap. `en` never asserts while in WAIT_ACK or WAIT_DONE.

Reset (asynchronous, any state):
- All outputs are 0: `en`, `music_note`, `music_time`, `fifo_full`, `fifo_level`.
- FSM goes to IDLE, `half`=0, FIFO is emptied.
- A command in flight is abandoned; the engine is not notified.

## Timing
- The time byte is sampled at edge N, where N is the cycle with `rx_valid`=1. The pair is visible in the FIFO at cycle N+1.
- With the FIFO empty and the FSM in IDLE, `en`=1 during cycle N+2. `music_note`/`music_time` are valid from that same cycle.
- `music_note`/`music_time` hold until the next pop.
- Back-to-back commands: minimum gap of 3 cycles from `busy` falling to the next `en` (WAIT_DONE→IDLE→ISSUE).
- `rx_valid` may assert every cycle; every byte is processed with no backpressure.
- `fifo_full` and `fifo_level` are registered and update the cycle after a push or pop.

## Configuration
- `MUSIC_NOTE_SEQ_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` [7:0]: a saturating count (stops at 255) of pairs dropped because the FIFO was full.
  - Reset value is 0.
  - Time-zero discards and resync discards are not counted.
- Macro undefined: the port and counter are absent. Dropping behaviour is otherwise identical.

## Structure
- Shared package `music_pkg`:
  - `MUSIC_RESYNC_BYTE` = 8'hFF
  - the FSM state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE)
  - the `music_cmd_t` struct {note[7:0], time[7:0]}
- Sub-module `music_cmd_fifo`: parameterised FIFO of `music_cmd_t` with push, pop, full, empty and level.
- Pairing logic and FSM stay in the top module.

## Test plan
- Single command: bytes 0x15, 0x20 with the engine model raising busy 1 cycle after `en` for 10 cycles. Expect one `en` at N+2, note=0x15, time=0x20, then IDLE after busy falls.
- Resync: bytes 0x15, 0xFF, 0x21, 0x08. Expect exactly one command, note=0x21, time=0x08.
- Overflow: hold busy=1, then push 10 pairs with `FIFO_DEPTH`=8. Expect `fifo_level`=8 and `fifo_full`=1, and `drop_cnt`=2 when the macro is defined. Release busy and expect the first 8 pairs issued in order.
- Ack timeout: the engine never raises busy. Expect `en` pulses spaced exactly `ACK_WAIT`+2 cycles apart until the FIFO drains.
- Time zero: bytes 0x30, 0x00. Expect no push, no `en`, and `half` back to 0 (the next pair 0x31, 0x05 issues correctly).
- Reset mid-WAIT_DONE with 3 pairs queued. Expect all outputs 0 immediately, `fifo_level`=0, and no `en` after reset is released.
